fetch_stage: RTL
================

Name: fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage pipelined MIPS core: PC register, imem request, and the IF/ID pipeline latch.
- Sits directly upstream of decode. Consumes the hazard unit's pc_wen, stall_ifid and flush_ifid, plus the redirect target resolved in MEM.
- Tracks a redirect that arrives mid-miss, so a stale in-flight fetch is squashed rather than issued.
- Stops fetching on HALT.

Parameters:
- PC_INIT, 32'h00000000, PC value loaded on reset.
- HALT_OP, 6'b111111, opcode that stops fetch.

Ports:
- CLK  in  1  clock, rising edge.
- nRST  in  1  asynchronous active-low reset.
- ihit  in  1  imem returned imemload for imemaddr this cycle.
- imemload  in  32  fetched instruction.
- imemREN  out  1  instruction read request.
- imemaddr  out  32  fetch address (= PC).
- pc_wen  in  1  PC advance enable from hazard unit (0 = load-use freeze).
- stall_ifid  in  1  hold IF/ID contents.
- flush_ifid  in  1  bubble IF/ID.
- redirect_valid  in  1  one-cycle pulse: branch taken or jump resolved.
- redirect_addr  in  32  new PC when redirect_valid.
- instr_id  out  32  IF/ID instruction.
- pcplus4_id  out  32  IF/ID PC+4.
- valid_id  out  1  IF/ID holds a real instruction.
- halted  out  1  fetch stopped on HALT.

Behaviour:
- Reset (async, nRST=0):
  - pc=PC_INIT; state=BOOT; pend_valid=0, pend_addr=0.
  - instr_id=0, pcplus4_id=0, valid_id=0, halted=0, imemREN=0.
- imemaddr = pc, combinational.
- imemREN=1 only in FETCH.
- States:
  - BOOT: one cycle after reset release, no request. Always goes to FETCH.
  - FETCH: normal operation.
  - HALTED: imemREN=0, halted=1, pc frozen.
- advance = FETCH & ihit & pc_wen & !stall_ifid.
- PC update, in priority order:
  1. redirect_valid & advance: pc <= redirect_addr.
  2. advance & pend_valid: pc <= pend_addr; pend_valid <= 0.
  3. advance: pc <= pc+4 (mod 2^32; 32'hFFFFFFFC wraps to 0).
  4. redirect_valid & !advance: pend_valid <= 1; pend_addr <= redirect_addr. A later redirect overwrites the pending one.
  5. Otherwise: pc holds.
- squash = redirect_valid | pend_valid. The instruction returned on an advance cycle with squash=1 is discarded.
- IF/ID latch, priority flush > stall > load:
  - flush_ifid: instr_id=0, pcplus4_id=0, valid_id=0.
  - else stall_ifid: hold all.
  - else advance & !squash: instr_id=imemload, pcplus4_id=pc+4, valid_id=1.
  - else: bubble (instr_id=0, valid_id=0; pcplus4_id holds).
- HALT handling:
  - On a non-squashed load where imemload[31:26]==HALT_OP: load it, then go to HALTED next cycle. The PC still advances by 4 that cycle.
  - HALTED & redirect_valid (HALT was on the wrong path): pc <= redirect_addr; go to FETCH; halted=0. Applies immediately, no pending needed.
- Simultaneous events:
  - redirect with stall/pc_wen=0: goes to pending, applied at the next advance.
  - flush without redirect: IF/ID bubbled only; PC path unaffected.
  - ihit with pc_wen=0: imem result dropped; re-fetched next cycle (same imemaddr).
- Reset mid-miss or mid-pending: everything returns to reset values; pending redirect lost.

Optional Feature:
- FETCH_STATS_EN.
- When defined: adds outputs fetch_count[31:0] and miss_cycles[31:0], both reset to 0 and saturating at 32'hFFFFFFFF.
  - fetch_count increments on each non-squashed IF/ID load.
  - miss_cycles increments on each FETCH cycle with ihit=0.
- When undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Reset, then ihit=1 with pc_wen=1 every cycle:
  - BOOT cycle with imemREN=0.
  - imemaddr sequences 0,4,8.
  - valid_id=1 with pcplus4_id=4,8,12.
- ihit=0 for 3 cycles at pc=0x10:
  - pc holds 0x10.
  - valid_id=0 (bubbles).
  - On ihit, instr_id=imemload and pcplus4_id=0x14.
- Redirect while missing:
  - redirect_valid pulse (addr 0x40) with flush_ifid at pc=0x20, ihit=0; ihit arrives 2 cycles later.
  - That instruction is squashed (valid_id=0).
  - Next imemaddr=0x40.
- redirect_valid and ihit same cycle, addr 0x80:
  - pc=0x80 next cycle.
  - IF/ID bubbled.
  - No pending left.
- stall_ifid=1, pc_wen=0 for 2 cycles with ihit=1:
  - instr_id, pc held.
  - Release resumes from the same address.
- Fetch 32'hFFFFFFFF at 0x0C:
  - IF/ID loads it; halted=1 and imemREN=0 next cycle; pc=0x10 frozen.
  - Then redirect to 0x30: resumes FETCH at 0x30.

Source files
------------

// File: rtl/fetch_stage_if.sv
// fetch_stage bus: imem request/response, hazard controls, IF/ID outputs.
// FETCH_STATS_EN adds the fetch_count / miss_cycles outputs.
interface fetch_stage_if;
  logic        ihit;
  logic [31:0] imemload;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        pc_wen;
  logic        stall_ifid;
  logic        flush_ifid;
  logic        redirect_valid;
  logic [31:0] redirect_addr;
  logic [31:0] instr_id;
  logic [31:0] pcplus4_id;
  logic        valid_id;
  logic        halted;
`ifdef FETCH_STATS_EN
  logic [31:0] fetch_count;
  logic [31:0] miss_cycles;
`endif

  modport master (
    input  ihit, imemload, pc_wen,
    input  stall_ifid, flush_ifid,
    input  redirect_valid, redirect_addr,
    output imemREN, imemaddr,
    output instr_id, pcplus4_id,
    output valid_id, halted
`ifdef FETCH_STATS_EN
    , output fetch_count, miss_cycles
`endif
  );

  modport slave (
    output ihit, imemload, pc_wen,
    output stall_ifid, flush_ifid,
    output redirect_valid, redirect_addr,
    input  imemREN, imemaddr,
    input  instr_id, pcplus4_id,
    input  valid_id, halted
`ifdef FETCH_STATS_EN
    , input fetch_count, miss_cycles
`endif
  );
endinterface

// File: rtl/fetch_stage.sv
// MIPS IF stage: PC, imem request, pending redirect, IF/ID latch.
// Optional FETCH_STATS_EN: saturating fetch/miss counters.
module fetch_stage #(
  parameter logic [31:0] PC_INIT = 32'h00000000,
  parameter logic [5:0]  HALT_OP = 6'b111111
) (
  input logic         CLK,
  input logic         nRST,
  fetch_stage_if.master bus
);

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    FETCH  = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [31:0] r_pc, w_pc_nxt;
  logic        r_pend_valid, w_pend_valid_nxt;
  logic [31:0] r_pend_addr, w_pend_addr_nxt;
  logic [31:0] r_instr, r_pcplus4;
  logic        r_valid;

  logic        w_adv, w_squash, w_load;
  logic [31:0] w_pc4;

  assign w_pc4    = r_pc + 32'd4;
  assign w_adv    = (r_state == FETCH) & bus.ihit
                  & bus.pc_wen & ~bus.stall_ifid;
  assign w_squash = bus.redirect_valid | r_pend_valid;
  assign w_load   = w_adv & ~w_squash & ~bus.flush_ifid;

  // Next state, next PC and pending-redirect bookkeeping
  always_comb begin
    w_state_nxt      = r_state;
    w_pc_nxt         = r_pc;
    w_pend_valid_nxt = r_pend_valid;
    w_pend_addr_nxt  = r_pend_addr;
    unique case (r_state)
      BOOT: w_state_nxt = FETCH;
      FETCH: begin
        if (w_load && bus.imemload[31:26] == HALT_OP)
          w_state_nxt = HALTED;
      end
      HALTED: begin
        if (bus.redirect_valid) begin
          w_state_nxt = FETCH;
          w_pc_nxt    = bus.redirect_addr;
        end
      end
      default: w_state_nxt = BOOT;
    endcase
    // a redirect taken on an advance supersedes any older pending one
    if (r_state != HALTED) begin
      if (w_adv) begin
        w_pend_valid_nxt = 1'b0;
        if (bus.redirect_valid)
          w_pc_nxt = bus.redirect_addr;
        else if (r_pend_valid)
          w_pc_nxt = r_pend_addr;
        else
          w_pc_nxt = w_pc4;
      end else if (bus.redirect_valid) begin
        w_pend_valid_nxt = 1'b1;
        w_pend_addr_nxt  = bus.redirect_addr;
      end
    end
  end

  // State, PC and pending redirect registers
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state      <= BOOT;
      r_pc         <= PC_INIT;
      r_pend_valid <= 1'b0;
      r_pend_addr  <= 32'd0;
    end else begin
      r_state      <= w_state_nxt;
      r_pc         <= w_pc_nxt;
      r_pend_valid <= w_pend_valid_nxt;
      r_pend_addr  <= w_pend_addr_nxt;
    end
  end

  // IF/ID latch: flush beats stall beats load, otherwise bubble
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_instr   <= 32'd0;
      r_pcplus4 <= 32'd0;
      r_valid   <= 1'b0;
    end else if (bus.flush_ifid) begin
      r_instr   <= 32'd0;
      r_pcplus4 <= 32'd0;
      r_valid   <= 1'b0;
    end else if (!bus.stall_ifid) begin
      if (w_load) begin
        r_instr   <= bus.imemload;
        r_pcplus4 <= w_pc4;
        r_valid   <= 1'b1;
      end else begin
        r_instr   <= 32'd0;
        r_valid   <= 1'b0;
      end
    end
  end

  assign bus.imemREN    = (r_state == FETCH);
  assign bus.imemaddr   = r_pc;
  assign bus.halted     = (r_state == HALTED);
  assign bus.instr_id   = r_instr;
  assign bus.pcplus4_id = r_pcplus4;
  assign bus.valid_id   = r_valid;

`ifdef FETCH_STATS_EN
  logic [31:0] r_fetch_count, r_miss_cycles;

  // Saturating counters of IF/ID loads and FETCH miss cycles
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_fetch_count <= 32'd0;
      r_miss_cycles <= 32'd0;
    end else begin
      if (w_load && r_fetch_count != 32'hFFFFFFFF)
        r_fetch_count <= r_fetch_count + 32'd1;
      if (r_state == FETCH && !bus.ihit
          && r_miss_cycles != 32'hFFFFFFFF)
        r_miss_cycles <= r_miss_cycles + 32'd1;
    end
  end

  assign bus.fetch_count = r_fetch_count;
  assign bus.miss_cycles = r_miss_cycles;
`endif

endmodule
